decoder_nx_seq: RTL

Parametrised, sequential successor to the team's 4-to-16 one-hot decoder. It generalises the decode to N select bits and 2^N one-hot outputs, and adds a registered select index with four modes:

- **DIRECT**: static decode.
- **SCAN_UP / SCAN_DOWN**: auto-rotating one-hot scan with programmable dwell.
- **PULSE**: a one-shot timed strobe.

It sits between control logic and banks of per-channel enables (row/column strobes, chip-selects, mux selects).

---
 rtl/decoder_nx_seq.sv | 78 +++++++
 1 files changed

// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: N-to-2^N one-hot decoder with a registered index that is either static,
// scanning up or down with a programmable dwell, or driving a timed one-shot pulse.
module decoder_nx_seq #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    out,
    output logic [N-1:0]       idx,
    output logic               wrap,
    output logic               busy
);
    localparam int W = 2**N;

    // The low two bits of each active state match the mode code, so a load can cast straight in.
    typedef enum logic [2:0] {
        DIRECT    = 3'b000,
        SCAN_UP   = 3'b001,
        SCAN_DOWN = 3'b010,
        PULSE     = 3'b011,
        IDLE      = 3'b100
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic               wrap_q;
    logic               expire;

    // Compared before incrementing, so a full-scale dwell never needs an extra counter bit.
    assign expire = cnt == dwell_q;
    assign busy   = state != IDLE;
    assign out    = (busy && en) ? W'(1) << idx : '0;
    assign wrap   = wrap_q && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
        end else if (!en) begin
            wrap_q <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            wrap_q <= 1'b0;
        end else if (load) begin
            state   <= state_t'({1'b0, mode});
            idx     <= in;
            cnt     <= '0;
            dwell_q <= dwell;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (state inside {SCAN_UP, SCAN_DOWN, PULSE})
                cnt <= expire ? '0 : cnt + DWELL_W'(1);
            if (expire && state == SCAN_UP) begin
                idx    <= idx + N'(1);
                wrap_q <= &idx;
            end
            if (expire && state == SCAN_DOWN) begin
                idx    <= idx - N'(1);
                wrap_q <= ~|idx;
            end
            if (expire && state == PULSE)
                state <= IDLE;
        end
    end
endmodule
